aes_enc_round_sequencer: RTL

//  Iterative AES-256 encryption controller. Accepts one 128-bit block over a valid/ready

---
 rtl/aes_enc_round_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/aes_enc_round_sequencer.sv
// aes_enc_round_sequencer: iterative AES-256 encryption round controller with valid/ready handshake
module aes_enc_round_sequencer #(
  parameter int NR = 14,
  parameter int IDX_W = 4
) (
  input  logic             inClk,
  input  logic             inRstN,
  input  logic [127:0]     inData,
  input  logic             inValid,
  output logic             outReady,
  output logic [IDX_W-1:0] outKeyIdx,
  input  logic [127:0]     inRoundKey0,
  input  logic [127:0]     inRoundKey1,
  output logic [127:0]     outData,
  output logic             outValid,
  input  logic             inReady,
  input  logic             inFlush,
  output logic             outBusy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAST = 2'd2, HOLD = 2'd3} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [127:0] st_q, st_d, data_q, data_d, u, t, m;
  logic valid_q, valid_d, accept;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = i == 1 ? p : gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  always_comb begin
    u = st_q ^ inRoundKey0;
    t = '0;
    m = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = sbox(u[127-8*(r+4*((c+r)%4)) -: 8]);
    for (int c = 0; c < 4; c++)
      m[127-32*c -: 32] = mix_col(t[127-32*c -: 32]);
  end
  assign outReady  = !inFlush && (state_q == IDLE || (state_q == HOLD && inReady));
  assign accept    = outReady && inValid;
  assign outKeyIdx = state_q == RUN ? cnt_q : state_q == LAST ? IDX_W'(NR - 1) : '0;
  assign outBusy   = state_q == RUN || state_q == LAST;
  assign outData   = data_q;
  assign outValid  = valid_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (inFlush) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      st_d    = inData;
      valid_d = 1'b0;
    end else if (state_q == RUN) begin
      st_d    = m;
      cnt_d   = cnt_q + IDX_W'(cnt_q != IDX_W'(NR - 1));
      state_d = cnt_q == IDX_W'(NR - 2) ? LAST : RUN;
    end else if (state_q == LAST) begin
      data_d  = t ^ inRoundKey1;
      valid_d = 1'b1;
      state_d = HOLD;
    end else if (state_q == HOLD && inReady) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule
